// File: rtl/jk_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_arbiter_pkg
// Description : JK op encodings and width helper shared by the arbiter files.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_bank_arbiter_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // Index width for n items; never below one bit so NREQ=1-style edge cases stay legal.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_arbiter_if
// Description : Requester-side request/op/mask bus and grant return path.
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_bank_arbiter_if
   import jk_bank_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);

   localparam int IDW = clog2(NREQ);

   logic [NREQ-1:0]       Req;
   logic [2*NREQ-1:0]     Op;
   logic [WIDTH*NREQ-1:0] Mask;
   logic [NREQ-1:0]       Gnt;
   logic [IDW-1:0]        GntId;

   modport master (
      output Req, Op, Mask,
      input  Gnt, GntId
   );

   modport slave (
      input  Req, Op, Mask,
      output Gnt, GntId
   );

endinterface
`default_nettype wire

// File: rtl/jk_bank_arbiter_jk_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : One JK bit with sync active-low reset, bank clear/set, enable.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cell
   import jk_bank_arbiter_pkg::*;
(
   input  wire logic Clk,
   input  wire logic Rn,
   input  wire logic i_clr,
   input  wire logic i_set,
   input  wire logic i_ce,
   input  wire logic i_j,
   input  wire logic i_k,
   output logic      o_q
);

   logic r_q;

   // Clear beats set, and both beat the arbitrated op.
   always_ff @(posedge Clk) begin
      if (!Rn) begin
         r_q <= 1'b0;
      end else if (i_clr) begin
         r_q <= 1'b0;
      end else if (i_set) begin
         r_q <= 1'b1;
      end else if (i_ce) begin
         case ({i_j, i_k})
            JK_HOLD: r_q <= r_q;
            JK_CLR:  r_q <= 1'b0;
            JK_SET:  r_q <= 1'b1;
            JK_TGL:  r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_arbiter
// Description : Round-robin arbiter applying one requester's JK op per clock
//               to a shared bank of JK bits.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter
   import jk_bank_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
)(
   input  wire logic          Clk,
   input  wire logic          Rn,
   input  wire logic          Clr,
   input  wire logic          Set,
   input  wire logic          En,
   jk_bank_arbiter_if.slave   bus,
   output logic [WIDTH-1:0]   Qout
);

   localparam int IDW = clog2(NREQ);

   logic [NREQ-1:0]  r_gnt;
   logic [IDW-1:0]   r_gntid;
   logic [IDW-1:0]   r_ptr;

   logic [NREQ-1:0]  w_elig;
   logic [IDW-1:0]   w_win;
   logic             w_found;
   logic             w_grant;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_q;
   int               w_idx;

   // Current grantee is masked out so a requester still holding Req in its
   // grant cycle cannot be serviced twice for one op.
   assign w_elig = bus.Req & ~r_gnt;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NREQ;
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_win   = IDW'(w_idx);
         end
      end
   end

   assign w_grant = En & ~Clr & ~Set & w_found;
   assign w_op    = bus.Op[2*w_win +: 2];
   assign w_mask  = bus.Mask[WIDTH*w_win +: WIDTH];

   always_ff @(posedge Clk) begin
      if (!Rn) begin
         r_gnt   <= '0;
         r_gntid <= '0;
         r_ptr   <= IDW'(NREQ - 1);
      end else if (w_grant) begin
         r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
         r_gntid <= w_win;
         r_ptr   <= w_win;
      end else begin
         r_gnt   <= '0;
      end
   end

   generate
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
         jk_cell u_cell (
            .Clk   (Clk),
            .Rn    (Rn),
            .i_clr (Clr),
            .i_set (Set),
            .i_ce  (w_grant & w_mask[b]),
            .i_j   (w_op[1]),
            .i_k   (w_op[0]),
            .o_q   (w_q[b])
         );
      end
   endgenerate

   assign bus.Gnt   = r_gnt;
   assign bus.GntId = r_gntid;
   assign Qout      = w_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_arbiter
// Description : Directed scoreboard bench for jk_bank_arbiter (NREQ=4, WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   typedef struct {
      logic [NREQ-1:0]  gnt;
      logic [1:0]       id;
      logic [WIDTH-1:0] q;
   } exp_t;

   logic             Clk;
   logic             Rn;
   logic             Clr;
   logic             Set;
   logic             En;
   logic [WIDTH-1:0] Qout;

   jk_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .Clk  (Clk),
      .Rn   (Rn),
      .Clr  (Clr),
      .Set  (Set),
      .En   (En),
      .bus  (bus),
      .Qout (Qout)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;

   exp_t sb[$];

   logic [WIDTH-1:0] m_q   = '0;
   logic [NREQ-1:0]  m_gnt = '0;
   logic [1:0]       m_id  = '0;
   int               m_ptr = NREQ - 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Predict the edge from the inputs now applied, then sample 1ns after it.
   task automatic cyc(input string tag);
      exp_t e;
      logic [NREQ-1:0] elig;
      logic [1:0] op;
      logic [WIDTH-1:0] mk;
      int w;
      if (!Rn) begin
         m_q = '0; m_gnt = '0; m_id = '0; m_ptr = NREQ - 1;
      end else if (Clr) begin
         m_q = '0; m_gnt = '0;
      end else if (Set) begin
         m_q = '1; m_gnt = '0;
      end else begin
         elig = bus.Req & ~m_gnt;
         w = -1;
         if (En) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
         end
         if (w >= 0) begin
            op = bus.Op[2*w +: 2];
            mk = bus.Mask[WIDTH*w +: WIDTH];
            for (int b = 0; b < WIDTH; b++) begin
               if (mk[b]) begin
                  if (op == 2'b01) m_q[b] = 1'b0;
                  else if (op == 2'b10) m_q[b] = 1'b1;
                  else if (op == 2'b11) m_q[b] = ~m_q[b];
               end
            end
            m_gnt = 4'b0001 << w;
            m_id  = 2'(w);
            m_ptr = w;
         end else begin
            m_gnt = '0;
         end
      end
      e.gnt = m_gnt; e.id = m_id; e.q = m_q;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".gnt"},   32'(bus.Gnt),   32'(e.gnt));
      chk({tag, ".gntid"}, 32'(bus.GntId), 32'(e.id));
      chk({tag, ".qout"},  32'(Qout),      32'(e.q));
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [WIDTH-1:0] mk);
      bus.Op[2*i +: 2]       = op;
      bus.Mask[WIDTH*i +: WIDTH] = mk;
   endtask

   logic [NREQ-1:0]  prev_gnt;
   int               gcnt [NREQ];
   logic [WIDTH-1:0] q_hold;

   initial begin
      Rn = 1'b0; Clr = 1'b0; Set = 1'b1; En = 1'b1;
      bus.Req = 4'hF; bus.Op = '0; bus.Mask = '0;

      // Reset dominates Set and pending requests
      cyc("rst0");
      cyc("rst1");
      chk("rst.qout", 32'(Qout), 32'h00);
      chk("rst.gnt", 32'(bus.Gnt), 32'h0);
      Rn = 1'b1; Set = 1'b0;
      cyc("rel");
      chk("rel.first_gnt", 32'(bus.Gnt), 32'b0001);
      bus.Req = 4'h0;
      cyc("idle0");

      // Single op, then a toggle while Req is still held through the grant cycle
      set_req(1, 2'b10, 8'h0F);
      bus.Req = 4'b0010;
      cyc("op_set");
      chk("op_set.qout", 32'(Qout), 32'h0F);
      chk("op_set.id", 32'(bus.GntId), 32'd1);
      set_req(1, 2'b11, 8'hFF);
      cyc("op_gap");
      chk("op_gap.no_regrant", 32'(bus.Gnt), 32'h0);
      cyc("op_tgl");
      chk("op_tgl.qout", 32'(Qout), 32'hF0);
      bus.Req = 4'h0;
      cyc("idle1");

      // Round robin with all four requesting, each toggling its own bit
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 2'b11, 8'(1 << i));
         gcnt[i] = 0;
      end
      bus.Req = 4'hF;
      prev_gnt = bus.Gnt;
      for (int n = 0; n < 12; n++) begin
         cyc("rr");
         chk("rr.onehot", 32'($countones(bus.Gnt)), 32'd1);
         chk("rr.no_back_to_back", 32'(bus.Gnt & prev_gnt), 32'h0);
         for (int i = 0; i < NREQ; i++) if (bus.Gnt[i]) gcnt[i]++;
         prev_gnt = bus.Gnt;
      end
      for (int i = 0; i < NREQ; i++) chk("rr.fair_count", 32'(gcnt[i]), 32'd3);

      // Clear and set override arbitration with requests pending
      Clr = 1'b1; Set = 1'b1;
      cyc("ovr_both");
      chk("ovr_both.qout", 32'(Qout), 32'h00);
      Clr = 1'b0;
      cyc("ovr_set");
      chk("ovr_set.qout", 32'(Qout), 32'hFF);
      Set = 1'b0;
      cyc("ovr_resume");
      chk("ovr_resume.ptr_kept", 32'(bus.Gnt), 32'b0100);
      bus.Req = 4'h0;
      cyc("idle2");

      // Enable low holds off grants
      En = 1'b0;
      bus.Req = 4'b1000;
      q_hold = Qout;
      for (int n = 0; n < 3; n++) begin
         cyc("en_off");
         chk("en_off.qout_static", 32'(Qout), 32'(q_hold));
      end
      En = 1'b1;
      cyc("en_on");
      chk("en_on.gnt", 32'(bus.Gnt), 32'b1000);
      bus.Req = 4'h0;
      cyc("idle3");

      // Reset during a would-be grant returns the pointer to favour requester 0
      bus.Req = 4'b0001;
      cyc("pre_rst");
      bus.Req = 4'b1001;
      Rn = 1'b0;
      cyc("mid_rst");
      chk("mid_rst.qout", 32'(Qout), 32'h00);
      chk("mid_rst.gnt", 32'(bus.Gnt), 32'h0);
      Rn = 1'b1;
      cyc("post_rst");
      chk("post_rst.req0_wins", 32'(bus.Gnt), 32'b0001);
      bus.Req = 4'h0;
      cyc("idle4");

      chk("sb.drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
